// File: rtl/d_latch_monitor.sv
// d_latch_monitor: checks observed D-latch pins (lat_en, lat_d, lat_q) against latch semantics and reports errors.
// Optional macro LATCH_MON_STICKY_EN adds err_sticky.
module d_latch_monitor #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16,
    parameter int GUARD = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             lat_en,
    input  logic [WIDTH-1:0] lat_d,
    input  logic [WIDTH-1:0] lat_q,
    output logic             err,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] trans_cycles,
    output logic [CNT_W-1:0] hold_cycles,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_got,
`ifdef LATCH_MON_STICKY_EN
    output logic             err_sticky,
`endif
    output logic [1:0]       mon_state
);
    typedef enum logic [1:0] {UNKNOWN = 2'b00, TRANSPARENT = 2'b01, HOLD = 2'b10} state_t;
    localparam logic [3:0] GUARD_V = 4'(GUARD);
    state_t           state, state_n;
    logic [WIDTH-1:0] stored, expected;
    logic [3:0]       guard, guard_n;
    logic             prev_en, armed, chg, skip, mis;
    always_ff @(posedge clock or posedge reset)
        if (reset) state <= UNKNOWN;
        else       state <= state_n;
    always_comb begin
        state_n  = lat_en ? TRANSPARENT : (state == UNKNOWN ? UNKNOWN : HOLD);
        chg      = lat_en != prev_en;
        // a transition sample is itself guarded whenever GUARD is nonzero
        skip     = chg ? (GUARD_V != 4'd0) : (guard != 4'd0);
        guard_n  = chg ? GUARD_V : (guard != 4'd0 ? guard - 4'd1 : 4'd0);
        expected = lat_en ? lat_d : stored;
        mis      = !skip && (lat_en || state != UNKNOWN) && (lat_q != expected);
    end
    assign mon_state = state;
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            stored       <= '0;
            guard        <= '0;
            prev_en      <= 1'b0;
            armed        <= 1'b1;
            err          <= 1'b0;
            err_count    <= '0;
            trans_cycles <= '0;
            hold_cycles  <= '0;
            first_exp    <= '0;
            first_got    <= '0;
        end else begin
            prev_en <= lat_en;
            guard   <= guard_n;
            err     <= mis;
            if (lat_en) stored <= lat_d;
            if (clear) begin
                err_count    <= '0;
                trans_cycles <= '0;
                hold_cycles  <= '0;
                first_exp    <= '0;
                first_got    <= '0;
                armed        <= 1'b1;
            end else begin
                if (mis && err_count != '1) err_count <= err_count + 1'b1;
                if (lat_en) trans_cycles <= trans_cycles + 1'b1;
                if (!lat_en && state == HOLD) hold_cycles <= hold_cycles + 1'b1;
                if (mis && armed) begin
                    first_exp <= expected;
                    first_got <= lat_q;
                    armed     <= 1'b0;
                end
            end
        end
`ifdef LATCH_MON_STICKY_EN
    // set alongside err so a same-cycle clear still wins
    always_ff @(posedge clock or posedge reset)
        if (reset) err_sticky <= 1'b0;
        else       err_sticky <= clear ? 1'b0 : (err_sticky | mis);
`endif
endmodule

// File: tb/tb_d_latch_monitor.sv
// tb_d_latch_monitor: directed checks of d_latch_monitor across three parameterisations.
module tb_d_latch_monitor;
    logic clock = 1'b0, reset = 1'b1;
    always #5 clock = ~clock;
    int passed = 0, total = 0;
    // instance a: WIDTH=8, GUARD=0
    logic a_clear = 0, a_en = 0, a_err;
    logic [7:0] a_d = 0, a_q = 0, a_fe, a_fg;
    logic [15:0] a_ec, a_tc, a_hc;
    logic [1:0] a_st;
    // instance b: WIDTH=8, CNT_W=4, GUARD=2
    logic b_clear = 0, b_en = 0, b_err;
    logic [7:0] b_d = 0, b_q = 0, b_fe, b_fg;
    logic [3:0] b_ec, b_tc, b_hc;
    logic [1:0] b_st;
    // instance c: default parameters
    logic c_clear = 0, c_en = 0, c_d = 0, c_q = 0, c_err, c_fe, c_fg;
    logic [15:0] c_ec, c_tc, c_hc;
    logic [1:0] c_st;
`ifdef LATCH_MON_STICKY_EN
    logic a_sticky, b_sticky, c_sticky;
`endif
    d_latch_monitor #(.WIDTH(8)) dut_a (
        .clock(clock), .reset(reset), .clear(a_clear), .lat_en(a_en), .lat_d(a_d), .lat_q(a_q),
        .err(a_err), .err_count(a_ec), .trans_cycles(a_tc), .hold_cycles(a_hc),
        .first_exp(a_fe), .first_got(a_fg),
`ifdef LATCH_MON_STICKY_EN
        .err_sticky(a_sticky),
`endif
        .mon_state(a_st));
    d_latch_monitor #(.WIDTH(8), .CNT_W(4), .GUARD(2)) dut_b (
        .clock(clock), .reset(reset), .clear(b_clear), .lat_en(b_en), .lat_d(b_d), .lat_q(b_q),
        .err(b_err), .err_count(b_ec), .trans_cycles(b_tc), .hold_cycles(b_hc),
        .first_exp(b_fe), .first_got(b_fg),
`ifdef LATCH_MON_STICKY_EN
        .err_sticky(b_sticky),
`endif
        .mon_state(b_st));
    d_latch_monitor dut (
        .clock(clock), .reset(reset), .clear(c_clear), .lat_en(c_en), .lat_d(c_d), .lat_q(c_q),
        .err(c_err), .err_count(c_ec), .trans_cycles(c_tc), .hold_cycles(c_hc),
        .first_exp(c_fe), .first_got(c_fg),
`ifdef LATCH_MON_STICKY_EN
        .err_sticky(c_sticky),
`endif
        .mon_state(c_st));
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask
    task automatic a_step(input logic clr, input logic en, input logic [7:0] d, input logic [7:0] q);
        a_clear = clr; a_en = en; a_d = d; a_q = q;
        @(posedge clock); #1;
    endtask
    task automatic b_step(input logic en, input logic [7:0] d, input logic [7:0] q);
        b_en = en; b_d = d; b_q = q;
        @(posedge clock); #1;
    endtask
    initial begin
        logic hold_v;
        logic [31:0] exp_ec;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_err", a_err, 0);
        chk("rst_ec", a_ec, 0);
        chk("rst_fe", a_fe, 0);
        chk("rst_st", a_st, 0);
        chk("rst_b_tc", b_tc, 0);
        reset = 1'b0;
        // ideal latch, en toggles each clock, d every two clocks
        hold_v = 1'b0;
        for (int i = 0; i < 40; i++) begin
            c_en = (i % 2) == 0;
            c_d  = ((i / 2) % 2) == 1;
            if (c_en) hold_v = c_d;
            c_q = c_en ? c_d : hold_v;
            @(posedge clock); #1;
            chk("t1_err", c_err, 0);
            chk("t1_st", c_st, c_en ? 2'b01 : 2'b10);
        end
        chk("t1_ec", c_ec, 0);
        chk("t1_tc", c_tc, 20);
        chk("t1_hc", c_hc, 0);
        // stale hold value injected while latch should hold A5
        a_step(0, 1, 8'hA5, 8'hA5);
        chk("t2_err0", a_err, 0);
        chk("t2_st0", a_st, 2'b01);
        a_step(0, 0, 8'h3C, 8'h3C);
        chk("t2_err1", a_err, 1);
        chk("t2_ec1", a_ec, 1);
        chk("t2_fe", a_fe, 8'hA5);
        chk("t2_fg", a_fg, 8'h3C);
        chk("t2_st1", a_st, 2'b10);
        a_step(0, 0, 8'h3C, 8'h3C);
        chk("t2_err2", a_err, 1);
        chk("t2_ec2", a_ec, 2);
        chk("t2_fg2", a_fg, 8'h3C);
        a_step(0, 0, 8'h3C, 8'hA5);
        chk("t2_err3", a_err, 0);
        chk("t2_ec3", a_ec, 2);
        chk("t2_hc", a_hc, 2);
        chk("t2_tc", a_tc, 1);
        // clear coincident with a mismatch
        a_step(1, 0, 8'h00, 8'h11);
        chk("t6_err", a_err, 1);
        chk("t6_ec", a_ec, 0);
        chk("t6_fe", a_fe, 0);
        chk("t6_fg", a_fg, 0);
        chk("t6_hc", a_hc, 0);
        chk("t6_tc", a_tc, 0);
`ifdef LATCH_MON_STICKY_EN
        chk("t6_sticky0", a_sticky, 0);
`endif
        a_step(0, 0, 8'h00, 8'h22);
        chk("t6_err2", a_err, 1);
        chk("t6_ec2", a_ec, 1);
        chk("t6_fe2", a_fe, 8'hA5);
        chk("t6_fg2", a_fg, 8'h22);
`ifdef LATCH_MON_STICKY_EN
        chk("t6_sticky1", a_sticky, 1);
`endif
        // asynchronous reset mid-operation, then undefined q with en low
        reset = 1'b1;
        #1;
        chk("t3_async_ec", a_ec, 0);
        chk("t3_async_fg", a_fg, 0);
        chk("t3_async_st", a_st, 0);
        chk("t3_async_err", a_err, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a_step(0, 0, 8'h00, 8'hFF);
            chk("t3_err", a_err, 0);
            chk("t3_st", a_st, 0);
        end
        chk("t3_hc", a_hc, 0);
        chk("t3_ec", a_ec, 0);
        // guard window of two after each en transition
        for (int i = 0; i < 4; i++) begin
            b_step(1, 8'h10, 8'h10);
            chk("t5_rise_err", b_err, 0);
        end
        b_step(0, 8'h77, 8'hEE);
        chk("t5_fall_err", b_err, 0);
        b_step(0, 8'h77, 8'hEE);
        chk("t5_g1_err", b_err, 0);
        b_step(0, 8'h77, 8'hEE);
        chk("t5_g2_err", b_err, 0);
        b_step(0, 8'h77, 8'hEE);
        chk("t5_third_err", b_err, 1);
        chk("t5_ec", b_ec, 1);
        chk("t5_fe", b_fe, 8'h10);
        chk("t5_fg", b_fg, 8'hEE);
        // sustained mismatch saturates the 4-bit count
        for (int i = 1; i <= 20; i++) begin
            b_step(0, 8'h77, 8'hEE);
            exp_ec = (i + 1 > 15) ? 15 : i + 1;
            chk("t4_err", b_err, 1);
            chk("t4_ec", b_ec, exp_ec);
        end
        chk("t4_hc_wrap", b_hc, 7);
        chk("t4_tc", b_tc, 4);
        chk("t4_fg", b_fg, 8'hEE);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
